// File: rtl/sorter_pkg.sv
// Shared types and ranking helper for the streaming top-K sorter.
// topk_better is a pure function; the caller supplies the real sample width.
package sorter_pkg;

  typedef enum logic [1:0] {TOPK_IDLE, TOPK_LOAD, TOPK_OUT} topk_state_e;

  localparam int TOPK_MAXW = 64;

  // Signed order maps onto unsigned order by inverting the sign bit.
  function automatic logic topk_better(input logic [TOPK_MAXW-1:0] a,
                                       input logic [TOPK_MAXW-1:0] b,
                                       input logic                 sign,
                                       input logic                 descend,
                                       input int unsigned          w);
    logic [TOPK_MAXW-1:0] m;
    logic [TOPK_MAXW-1:0] ka;
    logic [TOPK_MAXW-1:0] kb;
    m  = sign ? (TOPK_MAXW'(1) << (w - 1)) : '0;
    ka = a ^ m;
    kb = b ^ m;
    return descend ? (ka > kb) : (ka < kb);
  endfunction

endpackage

// File: rtl/topk_insert_cmp.sv
// Per-slot comparator: asserts take when the incoming sample belongs at or above this slot.
// Purely combinational; an equal sample never takes, which keeps ties in arrival order.
module topk_insert_cmp
  import sorter_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] i_slot_dat,
  input  logic                 i_slot_vld,
  input  logic [DATAWIDTH-1:0] i_smp_dat,
  input  logic                 i_sign,
  input  logic                 i_descend,
  output logic                 o_take
);

  assign o_take = !i_slot_vld ||
                  topk_better(TOPK_MAXW'(i_smp_dat), TOPK_MAXW'(i_slot_dat),
                              i_sign, i_descend, DATAWIDTH);

endmodule

// File: rtl/topk_stream_sorter.sv
// Streaming top-K selector; 1 sample/cycle, result one cycle after the last sample.
// Ready only while loading, result held until accepted. TOPK_INDEX_EN adds out_idx_o.
module topk_stream_sorter
  import sorter_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int K         = 8,
  parameter  int MAX_LEN   = 32,
  localparam int LENW      = $clog2(MAX_LEN + 1),
  localparam int CNTW      = $clog2(K + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   sign_ctrl_i,
  input  logic                   descend_i,
  input  logic [LENW-1:0]        len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATAWIDTH-1:0]   in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [K*DATAWIDTH-1:0] out_data_o,
`ifdef TOPK_INDEX_EN
  output logic [K*LENW-1:0]      out_idx_o,
`endif
  output logic [CNTW-1:0]        out_count_o,
  output logic                   busy_o
);

  topk_state_e          r_state;
  logic                 r_in_rdy;
  logic                 r_out_vld;
  logic                 r_busy;
  logic                 r_sign;
  logic                 r_desc;
  logic [LENW-1:0]      r_len;
  logic [LENW-1:0]      r_rcv;
  logic [CNTW-1:0]      r_cnt;
  logic [DATAWIDTH-1:0] r_slot [K];
  logic [DATAWIDTH-1:0] w_prev_slot [K];
  logic [K-1:0]         w_take;
  logic [K-1:0]         w_ins;
  logic [K-1:0]         w_shf;
  logic [LENW-1:0]      w_len;
  logic                 w_acc;
`ifdef TOPK_INDEX_EN
  logic [LENW-1:0]      r_idx [K];
  logic [LENW-1:0]      w_prev_idx [K];
`endif

  assign w_acc = in_valid_i && r_in_rdy;
  assign w_len = (len_i > LENW'(MAX_LEN)) ? LENW'(MAX_LEN) : len_i;

  // Filled slots are always contiguous from slot 0, so take is a thermometer code.
  for (genvar g = 0; g < K; g++) begin : g_slot
    topk_insert_cmp #(.DATAWIDTH(DATAWIDTH)) u_cmp (
      .i_slot_dat (r_slot[g]),
      .i_slot_vld (CNTW'(g) < r_cnt),
      .i_smp_dat  (in_data_i),
      .i_sign     (r_sign),
      .i_descend  (r_desc),
      .o_take     (w_take[g])
    );
    if (g == 0) begin : g_first
      assign w_ins[g]       = w_take[g];
      assign w_shf[g]       = 1'b0;
      assign w_prev_slot[g] = '0;
`ifdef TOPK_INDEX_EN
      assign w_prev_idx[g]  = '0;
`endif
    end else begin : g_rest
      assign w_ins[g]       = w_take[g] && !w_take[g-1];
      assign w_shf[g]       = w_take[g-1];
      assign w_prev_slot[g] = r_slot[g-1];
`ifdef TOPK_INDEX_EN
      assign w_prev_idx[g]  = r_idx[g-1];
`endif
    end
    assign out_data_o[g*DATAWIDTH +: DATAWIDTH] = r_slot[g];
`ifdef TOPK_INDEX_EN
    assign out_idx_o[g*LENW +: LENW] = r_idx[g];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= TOPK_IDLE;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_sign    <= 1'b0;
      r_desc    <= 1'b0;
      r_len     <= '0;
      r_rcv     <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < K; i++) begin
        r_slot[i] <= '0;
`ifdef TOPK_INDEX_EN
        r_idx[i]  <= '0;
`endif
      end
    end else begin
      case (r_state)
        TOPK_IDLE: begin
          if (start_i) begin
            r_sign <= sign_ctrl_i;
            r_desc <= descend_i;
            r_len  <= w_len;
            r_rcv  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            for (int i = 0; i < K; i++) begin
              r_slot[i] <= '0;
`ifdef TOPK_INDEX_EN
              r_idx[i]  <= '0;
`endif
            end
            if (w_len == '0) begin
              r_state   <= TOPK_OUT;
              r_out_vld <= 1'b1;
            end else begin
              r_state  <= TOPK_LOAD;
              r_in_rdy <= 1'b1;
            end
          end
        end
        TOPK_LOAD: begin
          if (w_acc) begin
            r_rcv <= r_rcv + LENW'(1);
            if (r_cnt != CNTW'(K)) r_cnt <= r_cnt + CNTW'(1);
            for (int i = 0; i < K; i++) begin
              if (w_ins[i]) begin
                r_slot[i] <= in_data_i;
`ifdef TOPK_INDEX_EN
                r_idx[i]  <= r_rcv;
`endif
              end else if (w_shf[i]) begin
                r_slot[i] <= w_prev_slot[i];
`ifdef TOPK_INDEX_EN
                r_idx[i]  <= w_prev_idx[i];
`endif
              end
            end
            if (r_rcv + LENW'(1) == r_len) begin
              r_state   <= TOPK_OUT;
              r_in_rdy  <= 1'b0;
              r_out_vld <= 1'b1;
            end
          end
        end
        TOPK_OUT: begin
          if (out_ready_i) begin
            r_state   <= TOPK_IDLE;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= TOPK_IDLE;
          r_in_rdy  <= 1'b0;
          r_out_vld <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_rdy;
  assign out_valid_o = r_out_vld;
  assign busy_o      = r_busy;
  assign out_count_o = r_cnt;

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Self-checking bench for topk_stream_sorter: directed vector table, corner sequences
// and randomized sequences scored against a stable-sort reference model.
module tb_topk_stream_sorter;

  localparam int DW      = 8;
  localparam int K       = 8;
  localparam int MAX_LEN = 32;
  localparam int LENW    = $clog2(MAX_LEN + 1);
  localparam int CNTW    = $clog2(K + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              sign = 1'b0;
  logic              desc = 1'b0;
  logic [LENW-1:0]   len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready_o;
  logic [DW-1:0]     in_data = '0;
  logic              out_valid_o;
  logic              out_ready = 1'b0;
  logic [K*DW-1:0]   out_data_o;
  logic [K*LENW-1:0] out_idx_o;
  logic [CNTW-1:0]   out_count_o;
  logic              busy_o;

  always #5 clk = ~clk;

  topk_stream_sorter #(.DATAWIDTH(DW), .K(K), .MAX_LEN(MAX_LEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .sign_ctrl_i (sign),
    .descend_i   (desc),
    .len_i       (len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .out_data_o  (out_data_o),
`ifdef TOPK_INDEX_EN
    .out_idx_o   (out_idx_o),
`endif
    .out_count_o (out_count_o),
    .busy_o      (busy_o)
  );

`ifndef TOPK_INDEX_EN
  assign out_idx_o = '0;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0]     g_smp [64];
  logic [K*DW-1:0]   got_d, e_d;
  logic [K*LENW-1:0] got_i, e_i;
  int                got_c, e_c;

  typedef struct {
    bit            sg;
    bit            ds;
    int            len;
    logic [DW-1:0] s [10];
    logic [K*DW-1:0] exp_d;
    int            exp_c;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit ranks_before(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input bit sg, input bit ds);
    int va, vb;
    va = sg ? int'($signed(a)) : int'(a);
    vb = sg ? int'($signed(b)) : int'(b);
    return ds ? (va > vb) : (va < vb);
  endfunction

  // Reference: stable top-K via repeated selection of the best unused, earliest sample.
  task automatic model(input bit sg, input bit ds, input int raw_len);
    bit used [64];
    int L, best;
    L   = (raw_len > MAX_LEN) ? MAX_LEN : raw_len;
    e_c = (L < K) ? L : K;
    e_d = '0;
    e_i = '0;
    for (int j = 0; j < 64; j++) used[j] = 1'b0;
    for (int s = 0; s < e_c; s++) begin
      best = -1;
      for (int j = 0; j < L; j++)
        if (!used[j] && (best < 0 || ranks_before(g_smp[j], g_smp[best], sg, ds))) best = j;
      used[best] = 1'b1;
      e_d[s*DW +: DW]     = g_smp[best];
      e_i[s*LENW +: LENW] = LENW'(best);
    end
  endtask

  task automatic run_seq(input bit sg, input bit ds, input int raw_len, input bit gaps,
                         input int hold);
    int L, i, guard;
    bit acc, stable;
    L = (raw_len > MAX_LEN) ? MAX_LEN : raw_len;
    @(negedge clk);
    start = 1'b1; sign = sg; desc = ds; len = LENW'(raw_len);
    @(negedge clk);
    start = 1'b0;
    if (L == 0) begin
      chk("len0_out_valid_next_cycle", out_valid_o, 1);
      chk("len0_no_in_ready", in_ready_o, 0);
    end
    i = 0; guard = 0;
    while (i < L && guard < 4000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = g_smp[i];
      acc = in_valid && in_ready_o;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("out_valid_seen", out_valid_o, 1);
    got_d = out_data_o;
    got_c = int'(out_count_o);
    got_i = out_idx_o;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_data_o !== got_d || int'(out_count_o) != got_c || out_valid_o !== 1'b1)
        stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_handshake", {busy_o, out_valid_o, in_ready_o}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].sg = 0; tbl[0].ds = 1; tbl[0].len = 10;
    tbl[0].s = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd200, 8'd5, 8'd9, 8'd0, 8'd4, 8'd6};
    tbl[0].exp_d = 64'h0304050607_0909C8; tbl[0].exp_c = 8;
    tbl[1].sg = 1; tbl[1].ds = 1; tbl[1].len = 4;
    tbl[1].s = '{8'h80, 8'h7F, 8'hFF, 8'h01, 0, 0, 0, 0, 0, 0};
    tbl[1].exp_d = 64'h00000000_80FF017F; tbl[1].exp_c = 4;
    tbl[2].sg = 0; tbl[2].ds = 0; tbl[2].len = 0;
    tbl[2].s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].exp_d = 64'h0; tbl[2].exp_c = 0;
    tbl[3].sg = 0; tbl[3].ds = 0; tbl[3].len = 10;
    tbl[3].s = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd200, 8'd5, 8'd9, 8'd0, 8'd4, 8'd6};
    tbl[3].exp_d = 64'h09070605_04030100; tbl[3].exp_c = 8;
    tbl[4].sg = 1; tbl[4].ds = 0; tbl[4].len = 4;
    tbl[4].s = '{8'h80, 8'h7F, 8'hFF, 8'h01, 0, 0, 0, 0, 0, 0};
    tbl[4].exp_d = 64'h00000000_7F01FF80; tbl[4].exp_c = 4;
    tbl[5].sg = 0; tbl[5].ds = 1; tbl[5].len = 3;
    tbl[5].s = '{8'd5, 8'd5, 8'd2, 0, 0, 0, 0, 0, 0, 0};
    tbl[5].exp_d = 64'h00000000_00020505; tbl[5].exp_c = 3;

    #12;
    chk("reset_in_ready", in_ready_o, 0);
    chk("reset_out_valid", out_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_count", out_count_o, 0);
    chk("reset_data", out_data_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Abort after three of ten samples.
    for (int j = 0; j < 10; j++) g_smp[j] = DW'(j + 1);
    @(negedge clk);
    start = 1'b1; sign = 1'b0; desc = 1'b1; len = LENW'(10);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = g_smp[j];
      @(negedge clk);
    end
    chk("midseq_busy_before_reset", busy_o, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready_o, 0);
    chk("abort_out_valid", out_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_count", out_count_o, 0);
    chk("abort_data", out_data_o, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 10; j++) g_smp[j] = tbl[t].s[j];
      run_seq(tbl[t].sg, tbl[t].ds, tbl[t].len, 1'b1, (t == 0) ? 5 : 1);
      chk($sformatf("tbl%0d_data", t), got_d, tbl[t].exp_d);
      chk($sformatf("tbl%0d_count", t), got_c, tbl[t].exp_c);
`ifdef TOPK_INDEX_EN
      if (t == 5) chk("tbl5_tie_indices", got_i, 48'h2040);
`endif
    end

    for (int r = 0; r < 25; r++) begin
      int raw, mode;
      bit sg, ds;
      raw  = $urandom_range(0, 40);
      mode = $urandom_range(0, 2);
      sg   = 1'($urandom_range(0, 1));
      ds   = 1'($urandom_range(0, 1));
      for (int j = 0; j < 64; j++) begin
        if (mode == 0)      g_smp[j] = DW'($urandom_range(0, 255));
        else if (mode == 1) g_smp[j] = DW'($urandom_range(0, 3));
        else                g_smp[j] = DW'(8'h7E + $urandom_range(0, 3));
      end
      run_seq(sg, ds, raw, 1'b1, $urandom_range(0, 3));
      model(sg, ds, raw);
      chk($sformatf("rand%0d_data", r), got_d, e_d);
      chk($sformatf("rand%0d_count", r), got_c, e_c);
`ifdef TOPK_INDEX_EN
      chk($sformatf("rand%0d_idx", r), got_i, e_i);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
